// File: rtl/ascii_gen_pkg.sv
// Shared types and default constants for the ASCII stream generator.
package ascii_gen_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Character advance modes; encoding 2'b11 is reserved and behaves as hold.
   typedef enum logic [1:0] {
      MODE_INC  = 2'd0,
      MODE_DEC  = 2'd1,
      MODE_HOLD = 2'd2
   } mode_e;

   // Default geometry and wrap window ('a' .. 'z').
   localparam int CHAR_W_DEF  = 8;
   localparam int COUNT_W_DEF = 12;
   localparam int LO_CHAR_DEF = 97;
   localparam int HI_CHAR_DEF = 122;

endpackage

// File: rtl/ascii_stream_generator_if.sv
// Valid/ready character stream carrying one character per beat plus a
// last-beat marker.
interface ascii_stream_generator_if #(
   parameter int CHAR_W = 8
);
   logic              valid;
   logic [CHAR_W-1:0] data;
   logic              last;
   logic              ready;

   // Source side: drives the beat, observes backpressure.
   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   // Sink side: consumes the beat, drives backpressure.
   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/ascii_char_step.sv
// Next-character function: advances a character by mode and keeps it inside
// the [LO_CHAR, HI_CHAR] window by wrapping at the bounds.
module ascii_char_step
   import ascii_gen_pkg::*;
#(
   parameter int CHAR_W  = CHAR_W_DEF,
   parameter int LO_CHAR = LO_CHAR_DEF,
   parameter int HI_CHAR = HI_CHAR_DEF
) (
   input  logic [CHAR_W-1:0] char_i,
   input  logic [1:0]        mode_i,
   output logic [CHAR_W-1:0] char_o
);

   localparam logic [CHAR_W-1:0] LO  = CHAR_W'(LO_CHAR);
   localparam logic [CHAR_W-1:0] HI  = CHAR_W'(HI_CHAR);
   localparam logic [CHAR_W-1:0] ONE = CHAR_W'(1);

   // Pick the successor; the wrap tests use the window bounds rather than
   // CHAR_W overflow, so a window narrower than the full code space still wraps.
   always_comb begin
      // NOTE: default assignment first so every path drives char_o and no latch is inferred.
      char_o = char_i;
      case (mode_i)
         MODE_INC: char_o = (char_i >= HI) ? LO : char_i + ONE;
         MODE_DEC: char_o = (char_i <= LO) ? HI : char_i - ONE;
         default:  char_o = char_i;   // hold, and the reserved encoding
      endcase
   end

endmodule

// File: rtl/ascii_stream_generator.sv
// Burst generator: on start it emits len characters over a valid/ready stream,
// stepping each character by mode inside a wrap window, and reports beat
// count, busy and a completion pulse. Every output comes straight from a flop.
module ascii_stream_generator
   import ascii_gen_pkg::*;
#(
   parameter int CHAR_W  = CHAR_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF,
   parameter int LO_CHAR = LO_CHAR_DEF,
   parameter int HI_CHAR = HI_CHAR_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           mode_i,
   input  logic [CHAR_W-1:0]    first_char_i,
   input  logic [COUNT_W-1:0]   len_i,
   output logic [COUNT_W-1:0]   count_o,
   output logic                 busy_o,
   output logic                 done_o,
   ascii_stream_generator_if.master strm
);

   localparam logic [CHAR_W-1:0]  LO      = CHAR_W'(LO_CHAR);
   localparam logic [CHAR_W-1:0]  HI      = CHAR_W'(HI_CHAR);
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic [CHAR_W-1:0]    data_q,  data_d;
   logic                 last_q,  last_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;
   logic [1:0]           mode_q,  mode_d;
   logic [COUNT_W-1:0]   len_q,   len_d;

   logic                 transfer;
   logic                 start_burst;
   logic                 start_empty;
   logic [CHAR_W-1:0]    first_clamped;
   logic [CHAR_W-1:0]    step_char;
   logic [COUNT_W-1:0]   count_inc;

   assign transfer    = valid_q && strm.ready;
   assign start_burst = start_i && (len_i != '0);
   assign start_empty = start_i && (len_i == '0);
   assign count_inc   = count_q + CNT_ONE;

   // Out-of-window first characters start the burst at the low bound.
   assign first_clamped = ((first_char_i < LO) || (first_char_i > HI)) ? LO : first_char_i;

   ascii_char_step #(
      .CHAR_W  (CHAR_W),
      .LO_CHAR (LO_CHAR),
      .HI_CHAR (HI_CHAR)
   ) u_step (
      .char_i (data_q),
      .mode_i (mode_q),
      .char_o (step_char)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort outranks a same-cycle final transfer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_burst) state_d = RUN;
         RUN: begin
            if (abort_i)                 state_d = IDLE;
            else if (transfer && last_q) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; everything holds unless a case below changes it.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mode_d  = mode_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            if (start_burst) begin
               mode_d  = mode_i;
               len_d   = len_i;
               count_d = '0;
               data_d  = first_clamped;
               valid_d = 1'b1;
               last_d  = (len_i == CNT_ONE);
               busy_d  = 1'b1;
            end else if (start_empty) begin
               // Zero-length burst: nothing on the stream, just the completion pulse.
               count_d = '0;
               done_d  = 1'b1;
            end
         end
         RUN: begin
            if (abort_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (transfer) begin
               count_d = count_inc;
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  data_d = step_char;
                  // Beat about to be presented is number count_inc+1 of len.
                  last_d = (count_inc == (len_q - CNT_ONE));
               end
            end
         end
         default: begin
            // DONE: done pulse already registered on entry; busy is low.
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= LO;
         last_q  <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= MODE_INC;
         len_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
      end
   end

   assign strm.valid = valid_q;
   assign strm.data  = data_q;
   assign strm.last  = last_q;
   assign count_o    = count_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_ascii_stream_generator.sv
// Self-checking bench for ascii_stream_generator: expected beats are queued
// as each burst is launched and compared as the DUT hands them over.
module tb_ascii_stream_generator;
   import ascii_gen_pkg::*;

   localparam int CHAR_W  = 8;
   localparam int COUNT_W = 12;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start_i = 1'b0;
   logic               abort_i = 1'b0;
   logic [1:0]         mode_i = 2'd0;
   logic [CHAR_W-1:0]  first_char_i = '0;
   logic [COUNT_W-1:0] len_i = '0;
   logic [COUNT_W-1:0] count_o;
   logic               busy_o;
   logic               done_o;

   ascii_stream_generator_if #(.CHAR_W(CHAR_W)) strm_if ();

   ascii_stream_generator #(
      .CHAR_W  (CHAR_W),
      .COUNT_W (COUNT_W),
      .LO_CHAR (97),
      .HI_CHAR (122)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .mode_i       (mode_i),
      .first_char_i (first_char_i),
      .len_i        (len_i),
      .count_o      (count_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .strm         (strm_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CHAR_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    done_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [CHAR_W-1:0] d, input logic l);
      exp_q.push_back('{data: d, last: l});
   endtask

   // Called one time unit after an edge; returns one unit after the start edge.
   task automatic start_burst(input logic [CHAR_W-1:0] first, input logic [COUNT_W-1:0] len,
                              input logic [1:0] mode);
      first_char_i = first;
      len_i        = len;
      mode_i       = mode;
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy_o && !strm_if.valid) break;
         tick();
      end
      check("idle_timeout", {31'd0, busy_o}, 0);
      tick();
      tick();
   endtask

   // Monitor: samples mid-cycle; a beat counts when it will transfer on the next edge.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (done_o) done_seen++;
         if (strm_if.valid && strm_if.ready && !abort_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", {24'd0, strm_if.data}, {24'd0, e.data});
               check("beat_last", {31'd0, strm_if.last}, {31'd0, e.last});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      strm_if.ready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, strm_if.valid}, 0);
      check("rst_data",  {24'd0, strm_if.data}, 97);
      check("rst_last",  {31'd0, strm_if.last}, 0);
      check("rst_count", {20'd0, count_o}, 0);
      check("rst_busy",  {31'd0, busy_o}, 0);
      check("rst_done",  {31'd0, done_o}, 0);
      rst_n = 1'b1;
      tick();

      // Increment, no stall: done pulses one cycle after the last beat.
      push(97, 0); push(98, 0); push(99, 0); push(100, 0); push(101, 1);
      start_burst(97, 5, 2'd0);
      check("inc_valid0", {31'd0, strm_if.valid}, 1);
      check("inc_busy0",  {31'd0, busy_o}, 1);
      check("inc_count0", {20'd0, count_o}, 0);
      repeat (5) tick();
      check("inc_done",   {31'd0, done_o}, 1);
      check("inc_busy",   {31'd0, busy_o}, 0);
      check("inc_valid",  {31'd0, strm_if.valid}, 0);
      check("inc_count",  {20'd0, count_o}, 5);
      tick();
      check("inc_done_1cyc", {31'd0, done_o}, 0);
      check("inc_q_empty", exp_q.size(), 0);

      // Wrap upward then downward.
      push(121, 0); push(122, 0); push(97, 0); push(98, 1);
      start_burst(121, 4, 2'd0);
      wait_idle(50);
      check("wrap_inc_count", {20'd0, count_o}, 4);
      push(98, 0); push(97, 0); push(122, 1);
      start_burst(98, 3, 2'd1);
      wait_idle(50);
      check("wrap_dec_count", {20'd0, count_o}, 3);
      check("wrap_q_empty", exp_q.size(), 0);

      // Backpressure on beat 2.
      push(97, 0); push(98, 0); push(99, 1);
      start_burst(97, 3, 2'd0);
      tick();
      strm_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", {31'd0, strm_if.valid}, 1);
         check("stall_data",  {24'd0, strm_if.data}, 98);
         check("stall_last",  {31'd0, strm_if.last}, 0);
         check("stall_count", {20'd0, count_o}, 1);
      end
      strm_if.ready = 1'b1;
      wait_idle(50);
      check("stall_count_end", {20'd0, count_o}, 3);
      check("stall_q_empty", exp_q.size(), 0);

      // Zero-length burst: one done pulse, no beats.
      d0 = done_seen;
      start_burst(99, 0, 2'd0);
      check("len0_done",  {31'd0, done_o}, 1);
      check("len0_valid", {31'd0, strm_if.valid}, 0);
      check("len0_busy",  {31'd0, busy_o}, 0);
      check("len0_count", {20'd0, count_o}, 0);
      tick();
      check("len0_done_1cyc", {31'd0, done_o}, 0);
      tick();
      check("len0_done_pulses", done_seen - d0, 1);

      // Single beat with a clamped first character.
      push(97, 1);
      start_burst(65, 1, 2'd0);
      check("len1_data", {24'd0, strm_if.data}, 97);
      check("len1_last", {31'd0, strm_if.last}, 1);
      wait_idle(20);
      check("len1_count", {20'd0, count_o}, 1);

      // Abort after three beats, with an ignored start during RUN.
      push(97, 0); push(98, 0); push(99, 0);
      d0 = done_seen;
      start_burst(97, 10, 2'd0);
      tick();
      first_char_i = 110;
      len_i        = 2;
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
      tick();
      abort_i      = 1'b1;
      tick();
      abort_i      = 1'b0;
      check("abort_valid", {31'd0, strm_if.valid}, 0);
      check("abort_last",  {31'd0, strm_if.last}, 0);
      check("abort_busy",  {31'd0, busy_o}, 0);
      check("abort_count", {20'd0, count_o}, 3);
      check("abort_done",  {31'd0, done_o}, 0);
      tick();
      tick();
      check("abort_no_done", done_seen - d0, 0);
      check("abort_idle_valid", {31'd0, strm_if.valid}, 0);
      check("abort_q_empty", exp_q.size(), 0);

      // Reserved mode behaves as hold.
      push(100, 0); push(100, 1);
      start_burst(100, 2, 2'd3);
      wait_idle(20);
      check("mode3_count", {20'd0, count_o}, 2);

      // Asynchronous reset mid-burst.
      d0 = done_seen;
      push(105, 0);
      start_burst(105, 10, 2'd0);
      tick();
      strm_if.ready = 1'b0;
      tick();
      check("pre_rst_count", {20'd0, count_o}, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, strm_if.valid}, 0);
      check("arst_data",  {24'd0, strm_if.data}, 97);
      check("arst_last",  {31'd0, strm_if.last}, 0);
      check("arst_count", {20'd0, count_o}, 0);
      check("arst_busy",  {31'd0, busy_o}, 0);
      check("arst_done",  {31'd0, done_o}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      strm_if.ready = 1'b1;
      tick();
      check("post_rst_valid", {31'd0, strm_if.valid}, 0);
      check("post_rst_no_done", done_seen - d0, 0);

      // Hold mode after reset.
      push(120, 0); push(120, 0); push(120, 1);
      start_burst(120, 3, 2'd2);
      wait_idle(20);
      check("hold_count", {20'd0, count_o}, 3);
      check("final_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ascii_stream_generator.md
Name: ascii_stream_generator

Overview:
Parametrised successor to the team's ASCII test generator. On a start pulse it emits a programmable-length burst of ASCII characters over a valid/ready stream. Supported modes are increment, decrement and hold, with wrap-around inside a configurable character window. It feeds the text/VGA character pipeline as a test source and reports beat count, last beat and completion.

Parameters:
CHAR_W, 8, width of character data.
COUNT_W, 12, width of length and beat counter; maximum burst length is 2^COUNT_W-1.
LO_CHAR, 97, lowest character of the wrap window ('a').
HI_CHAR, 122, highest character of the wrap window ('z'); must satisfy LO_CHAR <= HI_CHAR.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  single-cycle request to begin a burst, honoured only in IDLE
abort_i  input  1  terminate a burst in progress
mode_i  input  2  00 increment, 01 decrement, 10 hold, 11 reserved (treated as hold); latched at start
first_char_i  input  CHAR_W  first character of the burst; latched at start
len_i  input  COUNT_W  number of beats in the burst; latched at start
ready_i  input  1  downstream ready
valid_o  output  1  character beat valid
data_o  output  CHAR_W  current character
last_o  output  1  current beat is the final beat of the burst
count_o  output  COUNT_W  number of beats accepted in the current or most recent burst
busy_o  output  1  high in RUN
done_o  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, valid_o=0, data_o=LO_CHAR, last_o=0, count_o=0, busy_o=0, done_o=0.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE, start_i with len_i != 0:
  - Latch mode and length. count_o clears to 0.
  - data_o loads first_char_i, clamped to LO_CHAR if it is outside [LO_CHAR, HI_CHAR].
  - valid_o=1, last_o=(len_i==1), busy_o=1. Enter RUN on the next edge.
  - First beat is visible one cycle after start_i.
- IDLE, start_i with len_i == 0: no beats are produced. done_o pulses on the next cycle and state stays IDLE; count_o clears to 0.
- RUN, beat transfer: a beat transfers on any edge where valid_o && ready_i.
  - On transfer, count_o increments.
  - If last_o was high: valid_o=0, last_o=0, enter DONE.
  - Otherwise data_o advances per mode and last_o is set when count_o+1 == len-1.
- RUN, stall: while valid_o && !ready_i, data_o, last_o and count_o hold exactly.
- Advance rules:
  - Increment: data+1; HI_CHAR wraps to LO_CHAR.
  - Decrement: data-1; LO_CHAR wraps to HI_CHAR.
  - Hold: data is unchanged.
- DONE: done_o=1 and busy_o=0 for exactly one cycle, then IDLE. count_o retains the final count until the next start.
- start_i in RUN or DONE is ignored; a new burst requires IDLE.
- abort_i in RUN has priority over a same-cycle transfer. The beat is not counted.
  - Next cycle: valid_o=0, last_o=0, busy_o=0, state IDLE, no done_o pulse.
  - count_o holds the beats accepted before the abort.
- abort_i in IDLE or DONE has no effect.
- Mode 11 behaves as hold.
- rst_n asserted mid-burst returns all outputs to their reset values immediately; no done_o pulse.
- Arithmetic is performed in CHAR_W bits. Wrap checks compare against the window bounds, not the natural overflow.

Decomposition:
- Shared package ascii_gen_pkg: state enum (IDLE, RUN, DONE), mode enum (MODE_INC, MODE_DEC, MODE_HOLD), default LO/HI character constants.
- One natural sub-module, ascii_char_step: a combinational next-character function taking current char and mode and applying window wrap, parametrised by CHAR_W, LO_CHAR and HI_CHAR.
- The FSM, handshake and counters stay in the top module.

Test Plan:
- Increment, no stall: first_char=97, len=5, mode inc, ready tied high -> data 97,98,99,100,101 on consecutive cycles; last on 101; count_o=5; done_o pulses one cycle after the last beat.
- Wrap: first_char=121, len=4, mode inc -> 121,122,97,98. Then decrement, first_char=98, len=3 -> 98,97,122.
- Backpressure: len=3, ready low for 4 cycles on beat 2 -> data_o, last_o and count_o are stable throughout; the sequence is still 97,98,99 with no duplicate or skipped beat.
- Edge lengths: len=0 -> no valid_o, done_o pulses once. len=1, first_char=65 (clamped) -> a single beat 97 with last_o=1.
- Abort and ignored start: len=10 aborted after 3 beats -> valid_o drops the next cycle, count_o=3, no done_o. start_i pulsed during RUN is ignored.
- Reset mid-burst: rst_n low asynchronously mid-burst -> outputs return to reset values at once. After release, a start with hold mode and first_char=120, len=3 -> 120,120,120.
